// File: rtl/hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_unit : register scoreboard, MDU occupancy and stall control for ID
// Revision    : 1.0
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int MDU_LATENCY = 4,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  rd_wen_i,
  input  logic                  mdu_op_i,
  input  logic                  flush_i,
  input  logic                  wb_wen_i,
  input  logic [4:0]            wb_waddr_i,
  output logic                  stall_o,
  output logic                  no_op_flag_o,
  output logic                  issue_o,
  output logic                  mdu_busy_o,
  output logic [31:0]           pending_o,
  output logic [WORD_WIDTH-1:0] stall_cnt_o
);

  localparam logic [3:0]            MDU_LOAD = 4'(MDU_LATENCY);
  localparam logic [WORD_WIDTH-1:0] CNT_ONE  = WORD_WIDTH'(1);

  logic [31:0]           pending_q, pending_d;
  logic [3:0]            mdu_cnt_q, mdu_cnt_d;
  logic [WORD_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic hazard_raw, hazard_waw, hazard_mdu, id_live;

  // Hazards look only at the registered scoreboard; a WB clear becomes
  // visible one cycle later, matching the register-bank write timing.
  assign hazard_raw = (rs1_used_i & pending_q[rs1_addr_i]) |
                      (rs2_used_i & pending_q[rs2_addr_i]);
  assign hazard_waw = rd_wen_i & pending_q[rd_addr_i];
  assign hazard_mdu = mdu_op_i & mdu_busy_o;
  assign id_live    = id_valid_i & ~flush_i;

  assign mdu_busy_o   = (mdu_cnt_q != 4'd0);
  assign stall_o      = id_live & (hazard_raw | hazard_waw | hazard_mdu);
  assign issue_o      = id_live & ~stall_o;
  assign no_op_flag_o = ~issue_o;
  assign pending_o    = pending_q;
  assign stall_cnt_o  = stall_cnt_q;

  always_comb begin
    pending_d = pending_q;
    if (wb_wen_i && (wb_waddr_i != 5'd0)) begin
      pending_d[wb_waddr_i] = 1'b0;
    end
    // Applied after the clear so a new writer of the same register wins.
    if (issue_o && rd_wen_i && (rd_addr_i != 5'd0)) begin
      pending_d[rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;

    mdu_cnt_d = mdu_cnt_q;
    if (issue_o && mdu_op_i) begin
      mdu_cnt_d = MDU_LOAD;
    end else if (mdu_cnt_q != 4'd0) begin
      mdu_cnt_d = mdu_cnt_q - 4'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {WORD_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 32'd0;
      mdu_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_unit : directed + random stimulus against a queue scoreboard
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int LAT    = 4;
  localparam int WW     = 5;
  localparam int CNTMAX = (1 << WW) - 1;

  typedef struct packed {
    logic       rst, idv, u1, u2, wen, mdu, fl, wbw;
    logic [4:0] a1, a2, rd, wa;
  } stim_t;

  typedef struct packed {
    logic          stall, issue, noop, busy;
    logic [31:0]   pend;
    logic [WW-1:0] scnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i, rs1_used_i, rs2_used_i, rd_wen_i, mdu_op_i, flush_i, wb_wen_i;
  logic [4:0]    rs1_addr_i, rs2_addr_i, rd_addr_i, wb_waddr_i;
  logic          stall_o, no_op_flag_o, issue_o, mdu_busy_o;
  logic [31:0]   pending_o;
  logic [WW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Reference state: which registers have a write in flight, remaining MDU
  // cycles, and number of stalled cycles.
  bit [31:0] m_pend;
  int        m_mdu;
  int        m_scnt;

  hazard_unit #(.MDU_LATENCY(LAT), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .mdu_op_i(mdu_op_i),
    .flush_i(flush_i), .wb_wen_i(wb_wen_i), .wb_waddr_i(wb_waddr_i),
    .stall_o(stall_o), .no_op_flag_o(no_op_flag_o), .issue_o(issue_o),
    .mdu_busy_o(mdu_busy_o), .pending_o(pending_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(logic idv, logic [4:0] a1, logic u1, logic [4:0] a2, logic u2,
                               logic [4:0] rd, logic wen, logic mdu, logic fl,
                               logic wbw, logic [4:0] wa, logic r);
    stim_t s;
    s.rst = r; s.idv = idv; s.a1 = a1; s.u1 = u1; s.a2 = a2; s.u2 = u2;
    s.rd = rd; s.wen = wen; s.mdu = mdu; s.fl = fl; s.wbw = wbw; s.wa = wa;
    return s;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit   blocked;
    blocked = (s.u1 && m_pend[s.a1]) || (s.u2 && m_pend[s.a2]) ||
              (s.wen && m_pend[s.rd]) || (s.mdu && m_mdu > 0);
    e.stall = s.idv && !s.fl && blocked;
    e.issue = s.idv && !s.fl && !blocked;
    e.noop  = !e.issue;
    e.busy  = (m_mdu > 0);
    e.pend  = m_pend;
    e.scnt  = WW'(m_scnt);
    return e;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    rst = s.rst; id_valid_i = s.idv; rs1_addr_i = s.a1; rs1_used_i = s.u1;
    rs2_addr_i = s.a2; rs2_used_i = s.u2; rd_addr_i = s.rd; rd_wen_i = s.wen;
    mdu_op_i = s.mdu; flush_i = s.fl; wb_wen_i = s.wbw; wb_waddr_i = s.wa;
    e = predict(s);
    q.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      m_pend = '0; m_mdu = 0; m_scnt = 0;
    end else begin
      if (s.wbw && s.wa != 0) m_pend[s.wa] = 1'b0;
      if (e.issue && s.wen && s.rd != 0) m_pend[s.rd] = 1'b1;
      if (e.issue && s.mdu) m_mdu = LAT;
      else if (m_mdu > 0) m_mdu = m_mdu - 1;
      if (e.stall && m_scnt < CNTMAX) m_scnt = m_scnt + 1;
    end
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o",      32'(stall_o),      32'(e.stall));
      chk("issue_o",      32'(issue_o),      32'(e.issue));
      chk("no_op_flag_o", 32'(no_op_flag_o), 32'(e.noop));
      chk("mdu_busy_o",   32'(mdu_busy_o),   32'(e.busy));
      chk("pending_o",    pending_o,         e.pend);
      chk("stall_cnt_o",  32'(stall_cnt_o),  32'(e.scnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_valid_i = 0; rs1_addr_i = 0; rs1_used_i = 0; rs2_addr_i = 0;
    rs2_used_i = 0; rd_addr_i = 0; rd_wen_i = 0; mdu_op_i = 0; flush_i = 0;
    wb_wen_i = 0; wb_waddr_i = 0;
    m_pend = '0; m_mdu = 0; m_scnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, idle ID
    step(st(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0));

    // RAW on x5 released one cycle after the WB write
    step(st(1, 0,0, 0,0, 5,1, 0,0, 0,0, 0));
    step(st(1, 5,1, 0,0, 6,0, 0,0, 0,0, 0));
    step(st(1, 5,1, 0,0, 6,0, 0,0, 1,5, 0));
    step(st(1, 5,1, 0,0, 6,0, 0,0, 0,0, 0));

    // Writes to x0 never become pending
    step(st(1, 0,0, 0,0, 0,1, 0,0, 0,0, 0));
    step(st(1, 0,1, 0,1, 0,1, 0,0, 0,0, 0));

    // MDU occupancy: second MDU op waits, plain op passes
    step(st(1, 0,0, 0,0, 0,0, 1,0, 0,0, 0));
    step(st(1, 1,1, 2,1, 3,0, 0,0, 0,0, 0));
    repeat (5) step(st(1, 1,1, 2,1, 0,0, 1,0, 0,0, 0));
    repeat (5) step(st(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0));

    // Same-cycle WB clear and new write of x7 keeps it pending
    step(st(1, 0,0, 0,0, 7,1, 0,0, 0,0, 0));
    step(st(1, 0,0, 0,0, 8,1, 0,0, 1,7, 0));
    step(st(1, 0,0, 0,0, 7,1, 0,0, 1,7, 0));
    step(st(1, 7,1, 0,0, 0,0, 0,0, 0,0, 0));

    // Flush squashes a hazarding instruction without touching state
    step(st(1, 7,1, 8,1, 9,1, 0,1, 0,0, 0));
    step(st(0, 0,0, 0,0, 0,0, 0,0, 1,7, 0));
    step(st(0, 0,0, 0,0, 0,0, 0,0, 1,8, 0));

    // Reset with x5/x7 pending and MDU counter at 3
    step(st(1, 0,0, 0,0, 5,1, 0,0, 0,0, 0));
    step(st(1, 0,0, 0,0, 7,1, 1,0, 0,0, 0));
    step(st(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0));
    step(st(1, 7,1, 0,0, 9,1, 1,0, 0,0, 1));
    step(st(1, 5,1, 7,1, 0,0, 1,0, 0,0, 0));

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      s = st($urandom_range(3,0) != 0,
             5'($urandom_range(7,0)), 1'($urandom), 5'($urandom_range(7,0)), 1'($urandom),
             5'($urandom_range(7,0)), 1'($urandom), $urandom_range(3,0) == 0,
             $urandom_range(7,0) == 0, $urandom_range(2,0) != 0,
             5'($urandom_range(7,0)), $urandom_range(79,0) == 0);
      step(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: MDU_LATENCY, default 4, multi-cycle divide/multiply unit occupancy in cycles; legal range 1..15.
REQ-002 Parameter: WORD_WIDTH, default 32, width of the stall counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 id_valid_i  input  1  ID holds a valid decoded instruction.
REQ-006 rs1_addr_i  input  5  source register 1 address (instruction bits 19:15).
REQ-007 rs2_addr_i  input  5  source register 2 address (instruction bits 24:20).
REQ-008 rs1_used_i  input  1  instruction reads rs1.
REQ-009 rs2_used_i  input  1  instruction reads rs2.
REQ-010 rd_addr_i  input  5  destination register address.
REQ-011 rd_wen_i  input  1  instruction writes rd (the write_en_o of the control unit).
REQ-012 mdu_op_i  input  1  instruction targets the MDU.
REQ-013 flush_i  input  1  taken branch/jump; squash the instruction currently in ID.
REQ-014 wb_wen_i  input  1  WB register-bank write this cycle.
REQ-015 wb_waddr_i  input  5  WB register-bank write address.
REQ-016 stall_o  output  1  hold IF/ID registers this cycle.
REQ-017 no_op_flag_o  output  1  inject a bubble into EX this cycle.
REQ-018 issue_o  output  1  ID instruction advances to EX this cycle.
REQ-019 mdu_busy_o  output  1  MDU occupancy counter non-zero.
REQ-020 pending_o  output  32  scoreboard vector; bit n set = write to xn outstanding.
REQ-021 stall_cnt_o  output  WORD_WIDTH  cycles with stall_o high since reset.

Function
REQ-022 hazard_raw SHALL be (rs1_used_i & pending[rs1_addr_i]) | (rs2_used_i & pending[rs2_addr_i]), evaluated on the registered scoreboard only (no WB bypass).
REQ-023 hazard_waw SHALL be rd_wen_i & pending[rd_addr_i].
REQ-024 hazard_mdu SHALL be mdu_op_i & mdu_busy_o.
REQ-025 stall_o SHALL be id_valid_i & ~flush_i & (hazard_raw | hazard_waw | hazard_mdu), combinational.
REQ-026 issue_o SHALL be id_valid_i & ~flush_i & ~stall_o; no_op_flag_o SHALL be ~issue_o.
REQ-027 pending[0] SHALL read 0 permanently; writes to x0 never set or clear any bit.
REQ-028 On issue_o with rd_wen_i and rd_addr_i != 0, pending[rd_addr_i] SHALL be set at the next edge.
REQ-029 On wb_wen_i with wb_waddr_i != 0, pending[wb_waddr_i] SHALL be cleared at the next edge.
REQ-030 Set and clear of the same bit in the same cycle SHALL leave the bit set (the new writer wins).
REQ-031 A register cleared by WB in cycle N SHALL stall a dependent read in cycle N and release it in N+1 (1-cycle read-after-write gap, matching the register-bank write timing).
REQ-032 The MDU counter (4 bits) SHALL load MDU_LATENCY on issue_o & mdu_op_i, decrement by 1 per cycle while non-zero, and never wrap below 0.
REQ-033 mdu_busy_o SHALL be (MDU counter != 0); an MDU op is issuable in the cycle the counter reads 0.
REQ-034 flush_i SHALL NOT alter the scoreboard or the MDU counter; instructions already issued still retire.
REQ-035 stall_cnt_o SHALL increment by 1 on every cycle with stall_o high and saturate at all-ones.
REQ-036 id_valid_i low SHALL force stall_o=0, issue_o=0 and no_op_flag_o=1.

Reset
REQ-037 While rst is high at an edge: pending_o=0, MDU counter=0, stall_cnt_o=0; combinational outputs follow from that state.
REQ-038 rst SHALL dominate every simultaneous issue, WB clear or counter event in the same cycle, including reset asserted while the MDU is busy.

Verification
REQ-039 Issue with rd=x5, rd_wen=1; next cycle read rs1=x5 -> stall_o=1, no_op_flag_o=1; wb_wen=1, waddr=5 at cycle N -> stall at N, issue_o=1 at N+1.
REQ-040 Issue with rd=x0, rd_wen=1; next instruction reads x0 -> pending_o=0, no stall.
REQ-041 MDU_LATENCY=4: MDU op issued at cycle 0; second MDU op presented from cycle 1 -> stall in cycles 1-4, issue at cycle 5; a non-MDU op presented in cycle 1 issues with no stall.
REQ-042 x7 pending; in the same cycle WB clears x7 and ID issues a new write to x7 -> pending[7] stays 1.
REQ-043 flush_i=1 on a RAW-hazard instruction -> stall_o=0, no_op_flag_o=1, stall_cnt_o unchanged, scoreboard unchanged.
REQ-044 rst asserted for one cycle with pending=0x0000_00A0 and MDU counter=3 -> next cycle pending_o=0, mdu_busy_o=0, stall_cnt_o=0.
